adder_tree_accum_ctrl: RTL
==========================

Name: adder_tree_accum_ctrl

Overview:
- Streaming reduce-and-accumulate controller around the signed adder tree.
- Accepts a programmed number of NumIn-wide vector beats over a valid/ready input. Each beat is reduced by the tree, registered once, and accumulated into a saturating accumulator.
- Presents one final sum per job on a valid/ready output.
- Sits between a vector producer (e.g. a MAC/partial-product array) and the result writeback.

Parameters:
- InWidth, 16, width of each signed input element.
- NumIn, 9, elements per beat, i.e. adder tree fan-in.
- AccWidth, 32, accumulator and output width. Elaboration check: AccWidth >= InWidth + $clog2(NumIn).
- MaxLen, 256, maximum beats per job. LenWidth = $clog2(MaxLen+1).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  job start pulse; sampled only in IDLE.
- len_i  in  LenWidth  beats in job, captured with start_i; 0..MaxLen.
- abort_i  in  1  synchronous job abort; wins over all other inputs.
- busy_o  out  1  high in any state other than IDLE.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat ready.
- in_data_i  in  NumIn x InWidth  signed input elements.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumer ready.
- out_sum_o  out  AccWidth  signed accumulated sum.
- out_ovf_o  out  1  sticky saturation flag for the job; valid with out_valid_o.

Behaviour:
- Reset (async assert, sync deassert by system) drives:
  - FSM to IDLE.
  - All counters, s1_valid and the accumulator to 0.
  - busy_o, in_ready_o, out_valid_o, out_ovf_o to 0; out_sum_o to 0.
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - start_i=1 with len_i>0: capture len, clear acc/ovf/beat count, go to RUN.
  - start_i=1 with len_i=0: clear acc, go directly to HOLD (sum 0, ovf 0).
  - len_i>MaxLen is clamped to MaxLen.
- RUN:
  - in_ready_o = 1 while beat count < len. It is not gated by out_ready_i or in_valid_i.
  - Handshake is in_valid_i & in_ready_o. On each handshake, the tree sum (full precision InWidth+$clog2(NumIn), sign-extended) is registered into s1_sum with s1_valid=1, and the beat count increments.
  - After the handshake that makes count==len, go to DRAIN. in_ready_o drops the next cycle.
- Accumulate stage, any state:
  - When s1_valid=1, acc <= sat(acc + sext(s1_sum)).
  - On signed overflow, saturate to +max or -min of AccWidth and set ovf sticky.
  - s1_valid clears when no new beat is accepted.
- DRAIN: wait for the last s1 entry to be accumulated, then go to HOLD.
- HOLD:
  - out_valid_o=1; out_sum_o/out_ovf_o are held stable until out_ready_i=1.
  - On handshake, go to IDLE the next cycle. start_i in the same cycle is ignored.
- Latency: out_valid_o rises exactly 2 cycles after the cycle of the last input handshake. With len=1 and in_valid_i held high: start in cycle 0, accept in cycle 1, out_valid_o in cycle 3.
- Throughput: one beat per cycle, no bubbles within a job. The next job can start the cycle after the output handshake.
- start_i outside IDLE is ignored and must not disturb the running job.
- abort_i=1 in any state:
  - Next cycle is IDLE with counters, s1_valid, acc and ovf cleared.
  - No output is produced; in_ready_o and out_valid_o deassert.
  - abort_i in the same cycle as start_i also leaves the block in IDLE.
- in_data_i is ignored when no handshake occurs; X on in_data_i must not propagate.
- out_valid_o must not drop without a handshake, except on abort or reset.

Test Plan:
- NumIn=9, len=1, beat all elements +1 -> out_sum_o=9, ovf=0, out_valid_o in cycle 3 after start in cycle 0.
- len=4, elements = i-4 (i=0..8) per beat, in_valid_i toggling 1/0 -> sum 0 each beat, out_sum_o=0, exactly 4 handshakes, in_ready_o low after the 4th.
- len=256, all elements +32767, AccWidth=24 -> saturates to 8388607, out_ovf_o=1. Repeat with -32768 -> -8388608, ovf=1.
- len=0 start -> out_valid_o the next cycle with out_sum_o=0. Hold out_ready_i=0 for 10 cycles -> sum stable; then handshake -> IDLE, busy_o=0.
- len=8, abort_i after 3 beats -> IDLE next cycle, no out_valid_o. New start with len=2 and beats summing 5 and 7 -> out_sum_o=12 (no residue).
- Assert rst_ni low mid-RUN -> all outputs 0 immediately. start_i pulsed during RUN/HOLD -> ignored, result unchanged.

Source files
------------

// File: rtl/adder_tree_accum_ctrl.sv
// rtl/adder_tree_accum_ctrl.sv - streaming adder-tree reduce and saturating accumulate controller
//
// Each job is a programmed number of NumIn-wide signed vector beats. Each beat is
// reduced by a full-precision adder tree and registered into stage s1. Stage s1 is
// then folded into a saturating accumulator. One sum per job is presented on a
// valid/ready output.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, len_i           job start pulse (sampled in IDLE) and beat count (clamped to MaxLen)
//   abort_i                  synchronous abort, overrides everything else
//   busy_o                   high whenever the FSM is not in IDLE
//   in_valid_i/in_ready_o    input beat handshake; in_data_i carries NumIn x InWidth elements
//   out_valid_o/out_ready_i  result handshake; out_sum_o is the sum, out_ovf_o is the sticky saturation flag
module adder_tree_accum_ctrl #(
    parameter int InWidth  = 16,
    parameter int NumIn    = 9,
    parameter int AccWidth = 32,
    parameter int MaxLen   = 256,
    localparam int LenWidth = $clog2(MaxLen + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [LenWidth-1:0]      len_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NumIn*InWidth-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [AccWidth-1:0]      out_sum_o,
    output logic                     out_ovf_o
);

    localparam int TreeWidth = InWidth + $clog2(NumIn);

    if (AccWidth < TreeWidth) begin : g_width_check
        $error("AccWidth too narrow for the adder tree output");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic signed [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [LenWidth-1:0]           len_q, cnt_q, len_clamped;
    logic                          s1_valid_q;
    logic signed [TreeWidth-1:0]   s1_sum_q, tree_sum;
    logic signed [InWidth-1:0]     elem;
    logic signed [AccWidth-1:0]    acc_q, acc_next;
    logic signed [AccWidth:0]      acc_wide;
    logic                          acc_sat;
    logic                          ovf_q;
    logic                          in_hs;

    assign len_clamped = (len_i > LenWidth'(MaxLen)) ? LenWidth'(MaxLen) : len_i;

    assign busy_o      = (state_q != IDLE);
    assign in_ready_o  = (state_q == RUN) && (cnt_q < len_q);
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == HOLD);
    assign out_sum_o   = acc_q;
    assign out_ovf_o   = ovf_q;

    // Full-precision reduction; the result width cannot overflow for NumIn terms.
    always_comb begin
        tree_sum = '0;
        elem     = '0;
        for (int i = 0; i < NumIn; i++) begin
            elem     = in_data_i[i*InWidth +: InWidth];
            tree_sum = tree_sum + TreeWidth'(elem);
        end
    end

    // One guard bit above the accumulator exposes signed overflow of the add.
    always_comb begin
        acc_wide = (AccWidth+1)'(acc_q) + (AccWidth+1)'(s1_sum_q);
        acc_sat  = (acc_wide[AccWidth] != acc_wide[AccWidth-1]);
        if (acc_sat) begin
            acc_next = acc_wide[AccWidth] ? AccMin : AccMax;
        end else begin
            acc_next = acc_wide[AccWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? HOLD : RUN;
                end
            end
            RUN: begin
                if (in_hs && ((cnt_q + 1'b1) == len_q)) begin
                    state_d = DRAIN;
                end
            end
            // The last beat sits in s1 during this single cycle and is folded into
            // the accumulator on the same edge that enters HOLD.
            DRAIN:   state_d = HOLD;
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (abort_i) begin
            len_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= in_hs;
            if (in_hs) begin
                s1_sum_q <= tree_sum;
                cnt_q    <= cnt_q + 1'b1;
            end
            if ((state_q == IDLE) && start_i) begin
                len_q <= len_clamped;
                cnt_q <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s1_valid_q) begin
                acc_q <= acc_next;
                if (acc_sat) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

endmodule
